dbg_uart_tx: RTL and testbench

Debug serial transmitter for the board-level debug header. The core's debug logic pushes bytes into a 4-entry FIFO. The block shifts each byte out as an 8N1 asynchronous frame on one TXD line, so an external host can capture execution trace and register dumps. It sits between the core debug unit and the debug connector and drives the TXD indicator LED net. It is fully synchronous to the core clock.

---
 rtl/dbg_uart_tx.sv | 176 +++++++++++++++++
 tb/tb_dbg_uart_tx.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_uart_tx.sv
// dbg_uart_tx: debug-header serial transmitter.
// 4-entry byte FIFO feeding an 8N1 frame shifter; TXD is driven straight
// from a flop and idles high. Back-to-back frames run with no idle gap.
module dbg_uart_tx #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [7:0] WR_DATA,
    input  logic       WR_EN,
    output logic       FULL,
    output logic [2:0] LEVEL,
    output logic       BUSY,
    output logic       OVF,
    output logic       TXD
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic [7:0] TIMER_LOAD = 8'(CLK_DIV - 1);

    logic [7:0] r_mem [0:3];
    logic [1:0] r_wptr;
    logic [1:0] r_rptr;
    logic [2:0] r_level;
    logic       r_full;
    logic       r_ovf;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_timer;
    logic [7:0] w_timer_nxt;
    logic [2:0] r_bit_idx;
    logic [2:0] w_idx_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic       r_txd;
    logic       w_txd_nxt;

    logic       w_push;
    logic       w_pop;
    logic [2:0] w_level_nxt;

    // A write is accepted only against the registered FULL; a simultaneous
    // pop does not make room in the same cycle.
    assign w_push      = WR_EN && !r_full;
    assign w_level_nxt = r_level + {2'b00, w_push} - {2'b00, w_pop};

    // FIFO storage: no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= WR_DATA;
        end
    end

    // FIFO pointers, occupancy, full flag and sticky overrun flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == 3'd4);
            if (WR_EN && r_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Frame FSM state, bit timer, shift register and TXD flop.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_idx <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_txd     <= w_txd_nxt;
        end
    end

    // Next-state logic; TXD's next value is decided here so the pin is a
    // pure flop output that already reflects the state being entered.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_idx_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
                if (r_level != 3'd0) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rptr];
                    w_timer_nxt = TIMER_LOAD;
                    w_txd_nxt   = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_timer == 8'd0) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = 3'd0;
                    w_timer_nxt = TIMER_LOAD;
                    w_txd_nxt   = r_shift[0];
                end else begin
                    w_timer_nxt = r_timer - 8'd1;
                end
            end
            S_DATA: begin
                if (r_timer == 8'd0) begin
                    w_timer_nxt = TIMER_LOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_txd_nxt   = 1'b1;
                    end else begin
                        w_shift_nxt = r_shift >> 1;
                        w_idx_nxt   = r_bit_idx + 3'd1;
                        w_txd_nxt   = r_shift[1];
                    end
                end else begin
                    w_timer_nxt = r_timer - 8'd1;
                end
            end
            S_STOP: begin
                if (r_timer == 8'd0) begin
                    if (r_level != 3'd0) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rptr];
                        w_timer_nxt = TIMER_LOAD;
                        w_txd_nxt   = 1'b0;
                        w_state_nxt = S_START;
                    end else begin
                        w_timer_nxt = 8'd0;
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer - 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_txd_nxt   = 1'b1;
            end
        endcase
    end

    assign FULL  = r_full;
    assign LEVEL = r_level;
    assign OVF   = r_ovf;
    assign TXD   = r_txd;
    assign BUSY  = (r_state != S_IDLE) || (r_level != 3'd0);

endmodule

// File: tb/tb_dbg_uart_tx.sv
// tb_dbg_uart_tx: directed bench for dbg_uart_tx at CLK_DIV=4 and CLK_DIV=16.
// A frame monitor per instance records every frame cycle-accurately.
module tb_dbg_uart_tx;

    logic       clk;
    logic       nRST;
    logic [7:0] wr_data4, wr_data16;
    logic       wr_en4, wr_en16;
    logic       full4, full16;
    logic [2:0] level4, level16;
    logic       busy4, busy16;
    logic       ovf4, ovf16;
    logic       txd4, txd16;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [9:0] bits;
        bit         bad;
        int         start;
    } frame_t;

    frame_t q4[$];
    frame_t q16[$];

    dbg_uart_tx #(.CLK_DIV(4)) dut4 (
        .CLK(clk), .nRST(nRST), .WR_DATA(wr_data4), .WR_EN(wr_en4),
        .FULL(full4), .LEVEL(level4), .BUSY(busy4), .OVF(ovf4), .TXD(txd4)
    );

    dbg_uart_tx #(.CLK_DIV(16)) dut16 (
        .CLK(clk), .nRST(nRST), .WR_DATA(wr_data16), .WR_EN(wr_en16),
        .FULL(full16), .LEVEL(level16), .BUSY(busy16), .OVF(ovf16), .TXD(txd16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Samples TXD every cycle; bit j is taken at the first cycle of the bit
    // and every later cycle of that bit must match it.
    task automatic monitor(input bit sel, input int div);
        logic [9:0] bits;
        bit         bad;
        bit         active;
        int         n;
        int         st;
        logic       t;
        frame_t     f;
        active = 1'b0;
        n = 0;
        st = 0;
        bits = '0;
        bad = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            t = sel ? txd16 : txd4;
            if (!nRST) begin
                active = 1'b0;
            end else begin
                if (!active && t == 1'b0) begin
                    active = 1'b1;
                    n = 0;
                    st = cyc;
                    bits = '0;
                    bad = 1'b0;
                end
                if (active) begin
                    if (n % div == 0) bits[n / div] = t;
                    else if (t !== bits[n / div]) bad = 1'b1;
                    n++;
                    if (n == 10 * div) begin
                        f.bits = bits;
                        f.bad = bad;
                        f.start = st;
                        if (sel) q16.push_back(f);
                        else q4.push_back(f);
                        active = 1'b0;
                    end
                end
            end
        end
    endtask

    initial monitor(1'b0, 4);
    initial monitor(1'b1, 16);

    task automatic do_reset;
        wr_en4 = 1'b0;
        wr_en16 = 1'b0;
        nRST = 1'b0;
        tick;
        tick;
        nRST = 1'b1;
        tick;
    endtask

    task automatic wait_idle(input bit sel, input int max, input string name);
        int k;
        for (k = 0; k < max; k++) begin
            if (!(sel ? busy16 : busy4)) break;
            tick;
        end
        checks++;
        if (k == max) begin
            errors++;
            $display("FAIL %s_idle_timeout: BUSY still 1 after %0d cycles, required 0", name, max);
        end
    endtask

    task automatic test_reset;
        wr_data4 = '0;
        wr_data16 = '0;
        wr_en4 = 1'b0;
        wr_en16 = 1'b0;
        nRST = 1'b0;
        tick;
        tick;
        checks++;
        if ({txd4, level4, full4, busy4, ovf4} !== {1'b1, 3'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset4: txd=%b level=%0d full=%b busy=%b ovf=%b, required 1 0 0 0 0",
                     txd4, level4, full4, busy4, ovf4);
        end
        checks++;
        if ({txd16, level16, full16, busy16, ovf16} !== {1'b1, 3'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset16: txd=%b level=%0d full=%b busy=%b ovf=%b, required 1 0 0 0 0",
                     txd16, level16, full16, busy16, ovf16);
        end
        nRST = 1'b1;
        repeat (20) tick;
        checks++;
        if (txd4 !== 1'b1 || busy4 !== 1'b0 || q4.size() != 0) begin
            errors++;
            $display("FAIL reset_release: txd=%b busy=%b frames=%0d, required 1 0 0", txd4, busy4, q4.size());
        end
    endtask

    task automatic test_single;
        int wcyc;
        int fall_cyc;
        logic [9:0] exp;
        q4.delete();
        wr_data4 = 8'hA5;
        wr_en4 = 1'b1;
        tick;
        wcyc = cyc;
        wr_en4 = 1'b0;
        checks++;
        if (level4 !== 3'd1 || txd4 !== 1'b1) begin
            errors++;
            $display("FAIL single_push: level=%0d txd=%b, required 1 1", level4, txd4);
        end
        fall_cyc = -1;
        for (int k = 0; k < 200; k++) begin
            tick;
            if (busy4 === 1'b0) begin
                fall_cyc = cyc;
                break;
            end
        end
        checks++;
        if (q4.size() != 1) begin
            errors++;
            $display("FAIL single_count: frames=%0d, required 1", q4.size());
        end else begin
            exp = 10'b1_1010_0101_0;
            checks++;
            if (q4[0].bits !== exp || q4[0].bad) begin
                errors++;
                $display("FAIL single_frame: bits=%b unstable=%0d, required %b stable", q4[0].bits, q4[0].bad, exp);
            end
            checks++;
            if (q4[0].start != wcyc + 1) begin
                errors++;
                $display("FAIL single_latency: start cycle=%0d, required %0d", q4[0].start, wcyc + 1);
            end
            checks++;
            if (fall_cyc != q4[0].start + 40) begin
                errors++;
                $display("FAIL single_busy_fall: cycle=%0d, required %0d", fall_cyc, q4[0].start + 40);
            end
        end
    endtask

    task automatic test_burst;
        logic [7:0] v [0:3];
        int maxlvl;
        bit sawfull;
        bit sawovf;
        int k;
        v[0] = 8'h00; v[1] = 8'hFF; v[2] = 8'h55; v[3] = 8'h81;
        q4.delete();
        maxlvl = 0;
        sawfull = 1'b0;
        sawovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_data4 = v[i];
            wr_en4 = 1'b1;
            tick;
            if (int'(level4) > maxlvl) maxlvl = int'(level4);
            if (full4) sawfull = 1'b1;
            if (ovf4) sawovf = 1'b1;
        end
        wr_en4 = 1'b0;
        for (k = 0; k < 400; k++) begin
            if (!busy4) break;
            tick;
            if (int'(level4) > maxlvl) maxlvl = int'(level4);
            if (full4) sawfull = 1'b1;
            if (ovf4) sawovf = 1'b1;
        end
        checks++;
        if (k == 400) begin
            errors++;
            $display("FAIL burst_idle_timeout: BUSY still 1, required 0");
        end
        checks++;
        if (maxlvl != 3 || sawfull || sawovf) begin
            errors++;
            $display("FAIL burst_flags: max_level=%0d full_seen=%0d ovf_seen=%0d, required 3 0 0", maxlvl, sawfull, sawovf);
        end
        checks++;
        if (q4.size() != 4) begin
            errors++;
            $display("FAIL burst_count: frames=%0d, required 4", q4.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q4[i].bits !== {1'b1, v[i], 1'b0} || q4[i].bad) begin
                    errors++;
                    $display("FAIL burst_frame%0d: bits=%b unstable=%0d, required %b", i, q4[i].bits, q4[i].bad, {1'b1, v[i], 1'b0});
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q4[i + 1].start - q4[i].start != 40) begin
                    errors++;
                    $display("FAIL burst_gap%0d: spacing=%0d, required 40", i, q4[i + 1].start - q4[i].start);
                end
            end
        end
    endtask

    task automatic test_overrun;
        logic [7:0] v [0:5];
        v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33; v[3] = 8'h44; v[4] = 8'h55; v[5] = 8'h66;
        q16.delete();
        for (int i = 0; i < 6; i++) begin
            wr_data16 = v[i];
            wr_en16 = 1'b1;
            tick;
            if (i == 4) begin
                checks++;
                if (level16 !== 3'd4 || full16 !== 1'b1 || ovf16 !== 1'b0) begin
                    errors++;
                    $display("FAIL ovr_fill: level=%0d full=%b ovf=%b, required 4 1 0", level16, full16, ovf16);
                end
            end
        end
        wr_en16 = 1'b0;
        checks++;
        if (level16 !== 3'd4 || ovf16 !== 1'b1) begin
            errors++;
            $display("FAIL ovr_drop: level=%0d ovf=%b, required 4 1", level16, ovf16);
        end
        wait_idle(1'b1, 1200, "ovr");
        checks++;
        if (q16.size() != 5) begin
            errors++;
            $display("FAIL ovr_count: frames=%0d, required 5", q16.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (q16[i].bits !== {1'b1, v[i], 1'b0} || q16[i].bad) begin
                    errors++;
                    $display("FAIL ovr_frame%0d: bits=%b unstable=%0d, required %b", i, q16[i].bits, q16[i].bad, {1'b1, v[i], 1'b0});
                end
            end
        end
    endtask

    task automatic test_full_pop_collision;
        logic [7:0] v [0:4];
        int e;
        v[0] = 8'hA1; v[1] = 8'hA2; v[2] = 8'hA3; v[3] = 8'hA4; v[4] = 8'hA5;
        do_reset;
        q16.delete();
        e = 0;
        for (int i = 0; i < 5; i++) begin
            wr_data16 = v[i];
            wr_en16 = 1'b1;
            tick;
            if (i == 0) e = cyc + 1;
        end
        wr_en16 = 1'b0;
        for (int k = 0; k < 400 && cyc < e + 159; k++) tick;
        checks++;
        if (level16 !== 3'd4 || full16 !== 1'b1 || ovf16 !== 1'b0) begin
            errors++;
            $display("FAIL coll_pre: level=%0d full=%b ovf=%b, required 4 1 0", level16, full16, ovf16);
        end
        wr_data16 = 8'hEE;
        wr_en16 = 1'b1;
        tick;
        wr_en16 = 1'b0;
        checks++;
        if (level16 !== 3'd3 || ovf16 !== 1'b1 || full16 !== 1'b0) begin
            errors++;
            $display("FAIL coll_post: level=%0d ovf=%b full=%b, required 3 1 0", level16, ovf16, full16);
        end
        wait_idle(1'b1, 1000, "coll");
        checks++;
        if (q16.size() != 5) begin
            errors++;
            $display("FAIL coll_count: frames=%0d, required 5", q16.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (q16[i].bits !== {1'b1, v[i], 1'b0} || q16[i].bad) begin
                    errors++;
                    $display("FAIL coll_frame%0d: bits=%b unstable=%0d, required %b", i, q16[i].bits, q16[i].bad, {1'b1, v[i], 1'b0});
                end
            end
            checks++;
            if (q16[4].start - q16[0].start != 640) begin
                errors++;
                $display("FAIL coll_contiguous: span=%0d, required 640", q16[4].start - q16[0].start);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int e;
        bit txd_bad;
        bit busy_bad;
        do_reset;
        q4.delete();
        e = 0;
        for (int i = 0; i < 6; i++) begin
            wr_data4 = (i == 0) ? 8'h0F : 8'(i);
            wr_en4 = 1'b1;
            tick;
            if (i == 0) e = cyc + 1;
        end
        wr_en4 = 1'b0;
        for (int k = 0; k < 100 && cyc < e + 17; k++) tick;
        checks++;
        if (txd4 !== 1'b1 || level4 !== 3'd4 || ovf4 !== 1'b1 || busy4 !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: txd=%b level=%0d ovf=%b busy=%b, required 1 4 1 1", txd4, level4, ovf4, busy4);
        end
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (txd4 !== 1'b1 || level4 !== 3'd0 || busy4 !== 1'b0 || ovf4 !== 1'b0 || full4 !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: txd=%b level=%0d busy=%b ovf=%b full=%b, required 1 0 0 0 0",
                     txd4, level4, busy4, ovf4, full4);
        end
        tick;
        nRST = 1'b1;
        txd_bad = 1'b0;
        busy_bad = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick;
            if (txd4 !== 1'b1) txd_bad = 1'b1;
            if (busy4 !== 1'b0) busy_bad = 1'b0 | 1'b1;
        end
        checks++;
        if (txd_bad || busy_bad || q4.size() != 0) begin
            errors++;
            $display("FAIL rst_quiet: txd_dropped=%0d busy_seen=%0d frames=%0d, required 0 0 0", txd_bad, busy_bad, q4.size());
        end
    endtask

    task automatic test_pointer_wrap;
        logic [7:0] v [0:9];
        v[0] = 8'h01; v[1] = 8'h23; v[2] = 8'h45; v[3] = 8'h67; v[4] = 8'h89;
        v[5] = 8'hAB; v[6] = 8'hCD; v[7] = 8'hEF; v[8] = 8'hF0; v[9] = 8'h0E;
        q4.delete();
        for (int i = 0; i < 10; i++) begin
            wr_data4 = v[i];
            wr_en4 = 1'b1;
            tick;
            wr_en4 = 1'b0;
            repeat (39) tick;
        end
        wait_idle(1'b0, 200, "wrap");
        checks++;
        if (level4 !== 3'd0) begin
            errors++;
            $display("FAIL wrap_level: level=%0d, required 0", level4);
        end
        checks++;
        if (q4.size() != 10) begin
            errors++;
            $display("FAIL wrap_count: frames=%0d, required 10", q4.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (q4[i].bits !== {1'b1, v[i], 1'b0} || q4[i].bad) begin
                    errors++;
                    $display("FAIL wrap_frame%0d: bits=%b unstable=%0d, required %b", i, q4[i].bits, q4[i].bad, {1'b1, v[i], 1'b0});
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_burst;
        test_overrun;
        test_full_pop_collision;
        test_reset_mid_frame;
        test_pointer_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
